// File: rtl/bl_order_gen_acc.sv
// Baseline-order generator for the X-engine: walks the half-matrix in offset order and
// tags each beat with index, conjugate, redundancy, end-of-pass and buffer-half flags.
module bl_order_gen_acc #(
    parameter int N_ANTS  = 16,
    parameter int ACC_LEN = 1,
    localparam int ANT_BITS = (N_ANTS > 2) ? $clog2(N_ANTS) : 1,
    localparam int N_BLS    = N_ANTS * (N_ANTS / 2 + 1),
    localparam int BL_BITS  = $clog2(N_BLS),
    localparam int ACC_BITS = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1
) (
    input  logic                clk,
    input  logic                sync,
    input  logic                en,
    output logic [ANT_BITS-1:0] ant_a,
    output logic [ANT_BITS-1:0] ant_b,
    output logic [BL_BITS-1:0]  bl_idx,
    output logic                conj,
    output logic                dup,
    output logic                last_bl,
    output logic                last_acc,
    output logic                buf_sel
);

    localparam int K_BITS = $clog2(N_ANTS / 2 + 1);

    localparam logic [ANT_BITS-1:0] HALF     = ANT_BITS'(N_ANTS / 2);
    localparam logic [ANT_BITS-1:0] LAST_ANT = ANT_BITS'(N_ANTS - 1);
    localparam logic [ANT_BITS-1:0] ONE_ANT  = ANT_BITS'(1);
    localparam logic [K_BITS-1:0]   K_MAX    = K_BITS'(N_ANTS / 2);
    localparam logic [K_BITS-1:0]   ONE_K    = K_BITS'(1);
    localparam logic [BL_BITS-1:0]  BL_LAST  = BL_BITS'(N_BLS - 1);
    localparam logic [BL_BITS-1:0]  ONE_BL   = BL_BITS'(1);
    localparam logic [ACC_BITS-1:0] ACC_LAST = ACC_BITS'(ACC_LEN - 1);
    localparam logic [ACC_BITS-1:0] ONE_ACC  = ACC_BITS'(1);

    // Power-up contents match the sync state.
    logic [ANT_BITS-1:0] r_a        = HALF;
    logic [ANT_BITS-1:0] r_b        = '0;
    logic [K_BITS-1:0]   r_k        = '0;
    logic [BL_BITS-1:0]  r_blIdx    = '0;
    logic [ACC_BITS-1:0] r_passCnt  = '0;
    logic                r_bufSel   = 1'b0;

    logic                w_kWrap;
    logic [ANT_BITS-1:0] w_aInc;
    logic [ANT_BITS-1:0] w_bInc;
    logic [ANT_BITS-1:0] w_aCol;

    // Modular increments use explicit compares so non-power-of-two counts wrap correctly.
    always_comb begin
        w_kWrap = (r_k == K_MAX);
        w_aInc  = (r_a == LAST_ANT) ? '0 : r_a + ONE_ANT;
        w_bInc  = (r_b == LAST_ANT) ? '0 : r_b + ONE_ANT;
        w_aCol  = (w_bInc >= HALF) ? w_bInc - HALF : w_bInc + HALF;
    end

    always_ff @(posedge clk) begin
        if (sync) begin
            r_a       <= HALF;
            r_b       <= '0;
            r_k       <= '0;
            r_blIdx   <= '0;
            r_passCnt <= '0;
            r_bufSel  <= 1'b0;
        end else if (en) begin
            if (w_kWrap) begin
                r_k <= '0;
                r_b <= w_bInc;
                r_a <= w_aCol;
            end else begin
                r_k <= r_k + ONE_K;
                r_a <= w_aInc;
            end
            r_blIdx <= last_bl ? '0 : r_blIdx + ONE_BL;
            if (last_bl) begin
                r_passCnt <= (r_passCnt == ACC_LAST) ? '0 : r_passCnt + ONE_ACC;
            end
            if (last_acc) begin
                r_bufSel <= ~r_bufSel;
            end
        end
    end

    // Baselines with a > b straddle the pipeline boundary and land in the other half.
    assign ant_a    = r_a;
    assign ant_b    = r_b;
    assign bl_idx   = r_blIdx;
    assign conj     = (r_a > r_b);
    assign dup      = (r_k == '0) && (r_b >= HALF);
    assign last_bl  = (r_blIdx == BL_LAST);
    assign last_acc = last_bl && (r_passCnt == ACC_LAST);
    assign buf_sel  = conj ? ~r_bufSel : r_bufSel;

endmodule

// File: tb/tb_bl_order_gen_acc.sv
// Scoreboard bench: four generator configurations share one stimulus stream and are
// checked every non-sync cycle against a sequence table built from the offset-order rule.
module tb_bl_order_gen_acc;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] idx;
        logic       conj;
        logic       dup;
        logic       lastBl;
        logic       lastAcc;
        logic       bufSel;
    } beat_t;

    typedef beat_t [3:0] cycleExp_t;

    localparam int NA [4] = '{16, 6, 2, 4};
    localparam int AL [4] = '{2, 3, 3, 2};
    localparam int MAX_BLS = 144;

    logic clk  = 1'b0;
    logic sync = 1'b0;
    logic en   = 1'b0;
    bit   running = 1'b0;

    int errors  = 0;
    int checks  = 0;
    int cycleNo = 0;

    cycleExp_t expQ[$];
    beat_t     actBeat [4];

    int seqA   [4][MAX_BLS];
    int seqB   [4][MAX_BLS];
    bit seqDup [4][MAX_BLS];
    int pos     [4];
    int passCnt [4];
    bit bufReg  [4];

    always #5 clk = ~clk;

    // One DUT per configuration, outputs widened into a common beat record.
    generate
        for (genvar g = 0; g < 4; g++) begin : gDut
            localparam int AB = (NA[g] > 2) ? $clog2(NA[g]) : 1;
            localparam int BB = $clog2(NA[g] * (NA[g] / 2 + 1));
            logic [AB-1:0] antA;
            logic [AB-1:0] antB;
            logic [BB-1:0] blIdx;
            logic          conjO;
            logic          dupO;
            logic          lastBlO;
            logic          lastAccO;
            logic          bufSelO;

            bl_order_gen_acc #(.N_ANTS(NA[g]), .ACC_LEN(AL[g])) uDut (
                .clk     (clk),
                .sync    (sync),
                .en      (en),
                .ant_a   (antA),
                .ant_b   (antB),
                .bl_idx  (blIdx),
                .conj    (conjO),
                .dup     (dupO),
                .last_bl (lastBlO),
                .last_acc(lastAccO),
                .buf_sel (bufSelO)
            );

            assign actBeat[g] = '{a: 8'(antA), b: 8'(antB), idx: 8'(blIdx), conj: conjO,
                                  dup: dupO, lastBl: lastBlO, lastAcc: lastAccO, bufSel: bufSelO};
        end
    endgenerate

    function automatic int nBls(input int i);
        return NA[i] * (NA[i] / 2 + 1);
    endfunction

    // The pass order written straight from the nested-loop definition.
    task automatic buildSequences();
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            for (int b = 0; b < NA[i]; b++) begin
                for (int k = 0; k <= NA[i] / 2; k++) begin
                    seqA[i][n]   = (b + NA[i] / 2 + k) % NA[i];
                    seqB[i][n]   = b;
                    seqDup[i][n] = (k == 0) && (b >= NA[i] / 2);
                    n++;
                end
            end
        end
    endtask

    task automatic resetModels();
        for (int i = 0; i < 4; i++) begin
            pos[i]     = 0;
            passCnt[i] = 0;
            bufReg[i]  = 1'b0;
        end
    endtask

    function automatic beat_t expectedBeat(input int i);
        beat_t e;
        int    p;
        p         = pos[i];
        e.a       = 8'(seqA[i][p]);
        e.b       = 8'(seqB[i][p]);
        e.idx     = 8'(p);
        e.conj    = seqA[i][p] > seqB[i][p];
        e.dup     = seqDup[i][p];
        e.lastBl  = (p == nBls(i) - 1);
        e.lastAcc = e.lastBl && (passCnt[i] == AL[i] - 1);
        e.bufSel  = bufReg[i] ^ e.conj;
        return e;
    endfunction

    task automatic advanceModel(input int i);
        if (pos[i] == nBls(i) - 1) begin
            pos[i] = 0;
            if (passCnt[i] == AL[i] - 1) begin
                passCnt[i] = 0;
                bufReg[i]  = ~bufReg[i];
            end else begin
                passCnt[i]++;
            end
        end else begin
            pos[i]++;
        end
    endtask

    // Drive one cycle of inputs and record what every DUT must show during it.
    task automatic applyStimulus(input bit s, input bit e);
        cycleExp_t ce;
        @(posedge clk);
        #1;
        sync = s;
        en   = e;
        cycleNo++;
        if (s) begin
            resetModels();
        end else begin
            for (int i = 0; i < 4; i++) ce[i] = expectedBeat(i);
            expQ.push_back(ce);
            if (e) begin
                for (int i = 0; i < 4; i++) advanceModel(i);
            end
        end
    endtask

    task automatic checkOutput(input int i, input beat_t act, input beat_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL beat dut%0d(N=%0d,ACC=%0d) cycle %0d: got a=%0d b=%0d idx=%0d conj=%0b dup=%0b lastBl=%0b lastAcc=%0b bufSel=%0b, want a=%0d b=%0d idx=%0d conj=%0b dup=%0b lastBl=%0b lastAcc=%0b bufSel=%0b",
                     i, NA[i], AL[i], cycleNo,
                     act.a, act.b, act.idx, act.conj, act.dup, act.lastBl, act.lastAcc, act.bufSel,
                     exp.a, exp.b, exp.idx, exp.conj, exp.dup, exp.lastBl, exp.lastAcc, exp.bufSel);
        end
    endtask

    // Monitor: every cycle without sync presents a beat that must match the queue head.
    always @(negedge clk) begin
        cycleExp_t ce;
        if (running && !sync) begin
            if (expQ.size() == 0) begin
                errors++;
                checks++;
                $display("[TB] FAIL scoreboard cycle %0d: got empty queue, want an expected beat", cycleNo);
            end else begin
                ce = expQ.pop_front();
                for (int i = 0; i < 4; i++) checkOutput(i, actBeat[i], ce[i]);
            end
        end
    end

    initial begin
        beat_t probe;
        int    steps;
        buildSequences();
        resetModels();
        running = 1'b1;

        // Power-up state, held with en low.
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);

        // Sync together with en, then a long unbroken run spanning several buffer flips.
        applyStimulus(1'b1, 1'b1);
        repeat (600) applyStimulus(1'b0, 1'b1);

        // Random stalls with occasional realigns.
        repeat (1500) applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7);

        // Realign exactly on the N=2 instance's last-of-accumulation beat.
        probe = expectedBeat(2);
        steps = 0;
        while (!probe.lastAcc && steps < 40) begin
            applyStimulus(1'b0, 1'b1);
            probe = expectedBeat(2);
            steps++;
        end
        applyStimulus(1'b1, 1'b1);
        repeat (30) applyStimulus(1'b0, 1'b1);

        // Realign without en, then resume.
        applyStimulus(1'b1, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b1);

        @(negedge clk);
        #1;
        running = 1'b0;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending beats, want 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
